// File: rtl/ripple_sampler.sv
// ripple_sampler
// ---------------------------------------------------------------------------
// Brings the output of a free-running 3-bit ripple counter into the clkr
// domain. Only values that have been seen unchanged for STABLE_N consecutive
// synchronized samples are accepted. Accepted values are turned into a wide
// running count, wraps of the 3-bit value are flagged, and each new running
// count is offered downstream on a valid/ready interface. If the consumer is
// busy, further updates are coalesced into a single pending reload.
//
// Optional feature: define RIPPLE_SAMPLER_OVF_EN to add the sticky `ovf`
// output, set when the running count carries out of EXT_W bits.
//
// Parameters:
//   EXT_W     width of the running count (>= 4)
//   STABLE_N  consecutive identical samples needed to accept a value (1..15)
//
// Ports:
//   clkr        sampling clock, rising edge
//   rst         asynchronous active-high reset
//   cnt_in      ripple counter value, [0:2], cnt_in[0] is the LSB
//   ext_count   running count
//   wrap_pulse  one-cycle pulse when the accepted 3-bit value wraps
//   out_valid   snapshot available
//   out_ready   consumer accepts snapshot
//   out_data    snapshot of ext_count
//   ovf         sticky overflow (only with RIPPLE_SAMPLER_OVF_EN)

module ripple_sampler #(
  parameter int EXT_W    = 8,
  parameter int STABLE_N = 2
) (
  input  logic             clkr,
  input  logic             rst,
  input  logic [0:2]       cnt_in,
  output logic [EXT_W-1:0] ext_count,
  output logic             wrap_pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXT_W-1:0] out_data
`ifdef RIPPLE_SAMPLER_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Run length saturates one above STABLE_N so the acceptance compare fires
  // exactly once per stable run.
  localparam logic [4:0] STABLE_C = 5'(STABLE_N);
  localparam logic [4:0] SAT_C    = 5'(STABLE_N + 1);

  logic [0:2]       sync1_r;
  logic [0:2]       sync2_r;
  logic [1:0]       vld_r;
  logic [2:0]       prev_sync_r;
  logic [4:0]       run_r;
  logic [4:0]       run_s;
  logic [2:0]       samp_s;
  logic             accept_s;
  logic [2:0]       delta_s;
  logic             xfer_s;

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       prev_val_r;
  logic [2:0]       prev_val_s;
  logic [EXT_W-1:0] ext_count_r;
  logic [EXT_W-1:0] ext_count_s;
  logic             wrap_r;
  logic             wrap_s;
  logic             out_valid_r;
  logic             out_valid_s;
  logic [EXT_W-1:0] out_data_r;
  logic [EXT_W-1:0] out_data_s;
  logic             pending_r;
  logic             pending_s;

`ifdef RIPPLE_SAMPLER_OVF_EN
  logic [EXT_W:0]   sum_s;
  logic             ovf_r;
  logic             ovf_s;
`else
  logic [EXT_W-1:0] sum_s;
`endif

  // Reorder the synchronized [0:2] bus into an ordinary integer.
  assign samp_s  = {sync2_r[2], sync2_r[1], sync2_r[0]};
  assign delta_s = samp_s - prev_val_r;
  assign xfer_s  = out_valid_r && out_ready;

`ifdef RIPPLE_SAMPLER_OVF_EN
  assign sum_s = {1'b0, ext_count_r} + {{(EXT_W-2){1'b0}}, delta_s};
`else
  assign sum_s = ext_count_r + {{(EXT_W-3){1'b0}}, delta_s};
`endif

  // Two-flop synchronizer plus a valid pipe so reset zeros are never counted as samples.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      sync1_r     <= 3'b000;
      sync2_r     <= 3'b000;
      vld_r       <= 2'b00;
      prev_sync_r <= 3'd0;
      run_r       <= 5'd0;
    end else begin
      sync1_r     <= cnt_in;
      sync2_r     <= sync1_r;
      vld_r       <= {vld_r[0], 1'b1};
      prev_sync_r <= samp_s;
      run_r       <= run_s;
    end
  end

  // Run length of the current synchronized value, counting this cycle's sample.
  always_comb begin
    run_s = 5'd0;
    if (!vld_r[1]) begin
      run_s = 5'd0;
    end else if ((run_r != 5'd0) && (samp_s == prev_sync_r)) begin
      if (run_r >= SAT_C) begin
        run_s = SAT_C;
      end else begin
        run_s = run_r + 5'd1;
      end
    end else begin
      run_s = 5'd1;
    end
  end

  // Once a baseline exists, a stable run only counts if it differs from it,
  // so a glitch away and back never yields a zero delta.
  assign accept_s = (run_s == STABLE_C) &&
                    ((state_r == INIT) || (samp_s != prev_val_r));

  // FSM and datapath state registers.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      state_r     <= INIT;
      prev_val_r  <= 3'd0;
      ext_count_r <= '0;
      wrap_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      pending_r   <= 1'b0;
`ifdef RIPPLE_SAMPLER_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      prev_val_r  <= prev_val_s;
      ext_count_r <= ext_count_s;
      wrap_r      <= wrap_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      pending_r   <= pending_s;
`ifdef RIPPLE_SAMPLER_OVF_EN
      ovf_r       <= ovf_s;
`endif
    end
  end

  // Next-state: accumulation runs in TRACK and HOLD; the case handles the handshake.
  always_comb begin
    state_s     = state_r;
    prev_val_s  = prev_val_r;
    ext_count_s = ext_count_r;
    wrap_s      = 1'b0;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    pending_s   = pending_r;
`ifdef RIPPLE_SAMPLER_OVF_EN
    ovf_s       = ovf_r;
`endif

    if (accept_s && (state_r != INIT)) begin
      ext_count_s = sum_s[EXT_W-1:0];
      prev_val_s  = samp_s;
      wrap_s      = (samp_s < prev_val_r);
`ifdef RIPPLE_SAMPLER_OVF_EN
      ovf_s       = ovf_r | sum_s[EXT_W];
`endif
    end else begin
      wrap_s = 1'b0;
    end

    case (state_r)
      INIT: begin
        out_valid_s = 1'b0;
        pending_s   = 1'b0;
        if (accept_s) begin
          prev_val_s = samp_s;
          state_s    = TRACK;
        end else begin
          state_s = INIT;
        end
      end
      TRACK: begin
        pending_s = 1'b0;
        if (accept_s) begin
          out_data_s  = ext_count_s;
          out_valid_s = 1'b1;
          state_s     = HOLD;
        end else begin
          out_valid_s = 1'b0;
          state_s     = TRACK;
        end
      end
      HOLD: begin
        out_valid_s = 1'b1;
        if (xfer_s) begin
          // Old snapshot leaves this edge; any newer value (pending or
          // arriving right now) is loaded in its place, coalesced.
          if (pending_r || accept_s) begin
            out_data_s = ext_count_s;
            pending_s  = 1'b0;
            state_s    = HOLD;
          end else begin
            out_valid_s = 1'b0;
            pending_s   = 1'b0;
            state_s     = TRACK;
          end
        end else begin
          if (accept_s) begin
            pending_s = 1'b1;
          end else begin
            pending_s = pending_r;
          end
        end
      end
      default: begin
        state_s     = INIT;
        out_valid_s = 1'b0;
        pending_s   = 1'b0;
      end
    endcase
  end

  assign ext_count  = ext_count_r;
  assign wrap_pulse = wrap_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
`ifdef RIPPLE_SAMPLER_OVF_EN
  assign ovf        = ovf_r;
`endif

endmodule
